// File: rtl/checkout_monitor.sv
// Checkout scan monitor: counts accepted scans, tracks the last item code, and
// latches a blinking alarm on stolen items until the clerk acknowledges it.
// Optional sale counter is enabled by defining CHECKOUT_SALE_COUNT_EN.
module checkout_monitor #(
    parameter int BLINK_DIV = 25000000,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan,
    input  logic [2:0]       UPC,
    input  logic             mark,
    input  logic             sale,
    input  logic             stolen,
    input  logic             ack,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] sale_count,
    output logic [2:0]       last_upc,
    output logic             alarm,
    output logic             alarm_led
);

    typedef enum logic {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [25:0]      BLINK_LAST = 26'(BLINK_DIV - 1);

    state_t           state_q;
    state_t           state_d;
    logic             scan_q;
    logic             scan_ev;
    logic             accept;
    logic [CNT_W-1:0] item_q;
    logic [2:0]       upc_q;
    logic [25:0]      blink_cnt;
    logic             led_q;

    // mark is carried on the interface but does not influence the monitor
    logic unused_inputs;
    assign unused_inputs = ^{mark, sale};

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q <= 1'b1;
        end else begin
            scan_q <= scan;
        end
    end

    assign scan_ev = scan & ~scan_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_ev) begin
                    accept = 1'b1;
                    if (stolen) begin
                        state_d = ALARM;
                    end
                end
            end
            ALARM: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            item_q <= '0;
            upc_q  <= 3'b000;
        end else if (accept) begin
            if (item_q != CNT_MAX) begin
                item_q <= item_q + CNT_ONE;
            end
            upc_q <= UPC;
        end
    end

    // The LED starts lit on entry and flips each time the divider wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= 26'd0;
            led_q     <= 1'b0;
        end else if (state_d == ALARM) begin
            if (state_q == IDLE) begin
                blink_cnt <= 26'd0;
                led_q     <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= 26'd0;
                led_q     <= ~led_q;
            end else begin
                blink_cnt <= blink_cnt + 26'd1;
            end
        end else begin
            blink_cnt <= 26'd0;
            led_q     <= 1'b0;
        end
    end

`ifdef CHECKOUT_SALE_COUNT_EN
    logic [CNT_W-1:0] sale_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sale_q <= '0;
        end else if (accept && sale && (sale_q != CNT_MAX)) begin
            sale_q <= sale_q + CNT_ONE;
        end
    end

    assign sale_count = sale_q;
`else
    assign sale_count = '0;
`endif

    assign item_count = item_q;
    assign last_upc   = upc_q;
    assign alarm      = (state_q == ALARM);
    assign alarm_led  = led_q;

endmodule

// File: tb/tb_checkout_monitor.sv
// Randomised scoreboard bench for checkout_monitor with a cycle-level reference
// model; directed scenarios first, then random traffic with rare resets.
module tb_checkout_monitor;

    localparam int BLINK_DIV = 4;
    localparam int CNT_W     = 2;
    localparam int W         = 2 * CNT_W + 5;
    localparam int MAXV      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             scan = 1'b0;
    logic [2:0]       UPC = 3'b000;
    logic             mark = 1'b0;
    logic             sale = 1'b0;
    logic             stolen = 1'b0;
    logic             ack = 1'b0;
    logic [CNT_W-1:0] item_count;
    logic [CNT_W-1:0] sale_count;
    logic [2:0]       last_upc;
    logic             alarm;
    logic             alarm_led;

    checkout_monitor #(.BLINK_DIV(BLINK_DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .scan(scan), .UPC(UPC), .mark(mark),
        .sale(sale), .stolen(stolen), .ack(ack), .item_count(item_count),
        .sale_count(sale_count), .last_upc(last_upc), .alarm(alarm),
        .alarm_led(alarm_led)
    );

    // clock
    always #5 clk = ~clk;

    // reference model state
    int m_items = 0;
    int m_sales = 0;
    int m_upc = 0;
    bit m_alarm = 0;
    int m_acyc = 0;
    bit m_prev_scan = 1;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    function automatic void model_step(input bit r, input bit s, input int u,
                                       input bit sa, input bit st, input bit a);
        bit ev;
        if (r) begin
            m_items = 0; m_sales = 0; m_upc = 0; m_alarm = 0; m_acyc = 0;
            m_prev_scan = 1;
        end else begin
            ev = s && !m_prev_scan;
            m_prev_scan = s;
            if (!m_alarm) begin
                if (ev) begin
                    if (m_items < MAXV) m_items++;
                    if (sa && m_sales < MAXV) m_sales++;
                    m_upc = u;
                    if (st) begin
                        m_alarm = 1;
                        m_acyc = 0;
                    end
                end
            end else if (a) begin
                m_alarm = 0;
            end else begin
                m_acyc++;
            end
        end
    endfunction

    function automatic logic [W-1:0] model_expect();
        int  sales_exp;
        bit  led_exp;
`ifdef CHECKOUT_SALE_COUNT_EN
        sales_exp = m_sales;
`else
        sales_exp = 0;
`endif
        led_exp = m_alarm && (((m_acyc / BLINK_DIV) % 2) == 0);
        return {CNT_W'(m_items), CNT_W'(sales_exp), 3'(m_upc), m_alarm, led_exp};
    endfunction

    // driver
    task automatic step(input bit r, input bit s, input int u,
                        input bit sa, input bit st, input bit a);
        @(negedge clk);
        reset  = r;
        scan   = s;
        UPC    = 3'(u);
        mark   = 1'($urandom_range(0, 1));
        sale   = sa;
        stolen = st;
        ack    = a;
        model_step(r, s, u, sa, st, a);
        exp_q.push_back(model_expect());
    endtask

    task automatic press(input int u, input bit sa, input bit st);
        step(0, 1, u, sa, st, 0);
        step(0, 0, u, sa, st, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("item_count", int'(item_count), int'(e[W-1 -: CNT_W]));
                chk("sale_count", int'(sale_count), int'(e[W-CNT_W-1 -: CNT_W]));
                chk("last_upc", int'(last_upc), int'(e[4:2]));
                chk("alarm", int'(alarm), int'(e[1]));
                chk("alarm_led", int'(alarm_led), int'(e[0]));
            end
        end
    end

    initial begin
        // scan held high through reset and after release: no event
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 5, 1, 0, 0);
        step(0, 0, 5, 1, 0, 0);
        press(5, 1, 0);

        // three sale scans of item 2
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) press(2, 1, 0);
        // saturation, then a stolen scan still alarms
        press(6, 1, 0);
        press(7, 1, 0);
        press(1, 0, 1);
        // scans ignored in alarm, blink for a while
        press(4, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);
        // ack coincident with a scan edge drops the scan
        step(0, 1, 3, 1, 0, 1);
        step(0, 0, 3, 0, 0, 0);
        // ack in idle is harmless
        step(0, 0, 0, 0, 0, 1);

        // reset in the middle of an alarm
        step(1, 0, 0, 0, 0, 0);
        press(0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        press(6, 1, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        end
        step(0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
